// File: rtl/genclk_return_capture.sv
// Divide-by-DIV clock generator with a slow-to-fast return capture into a 2-entry FIFO.
// Define GENCLK_RETURN_COUNT_EN to add the saturating cap_count output.
module genclk_return_capture #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   div_clk,
    input  logic [WIDTH-1:0]       slow_data,
    input  logic                   slow_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
`ifdef GENCLK_RETURN_COUNT_EN
    output logic [15:0]            cap_count,
`endif
    output logic [$clog2(DIV)-1:0] phase
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF   = PW'(DIV / 2);
    localparam logic [PW-1:0] STROBE = PW'(DIV / 2 - 1);

    logic [PW-1:0]    next_phase;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             cap;
    logic             pop;
    logic             push_ok;

    always_comb begin
        next_phase = (phase == LAST) ? '0 : phase + 1'b1;
    end

    // Strobe in the last fast cycle before div_clk rises: slow data is settled.
    assign cap       = en && (phase == STROBE) && slow_valid;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = cap && ((count != 2'd2) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            div_clk <= 1'b0;
        end else if (en) begin
            phase   <= next_phase;
            div_clk <= (next_phase >= HALF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            tail     <= '0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (count == 2'd0) out_data <= slow_data;
                    else               tail     <= slow_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    out_data <= tail;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    // Count stays; the new word lands behind whatever survives the pop.
                    if (count == 2'd1) begin
                        out_data <= slow_data;
                    end else begin
                        out_data <= tail;
                        tail     <= slow_data;
                    end
                end
                default: ;
            endcase
            if (cap && !push_ok) overflow <= 1'b1;
        end
    end

`ifdef GENCLK_RETURN_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_count <= 16'd0;
        end else if (push_ok && (cap_count != 16'hFFFF)) begin
            cap_count <= cap_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_genclk_return_capture.sv
// Randomized and directed bench for genclk_return_capture against a queue-based model.
module tb_genclk_return_capture;
    localparam int DIV   = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic             div_clk;
    logic [WIDTH-1:0] slow_data = '0;
    logic             slow_valid = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [1:0]       phase;
`ifdef GENCLK_RETURN_COUNT_EN
    logic [15:0]      cap_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    genclk_return_capture #(.DIV(DIV), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
        .slow_data(slow_data), .slow_valid(slow_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow),
`ifdef GENCLK_RETURN_COUNT_EN
        .cap_count(cap_count),
`endif
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: enabled-cycle counter, a bounded queue, sticky drop flag.
    int               m_cyc = 0;
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf = 1'b0;
    int               m_cnt = 0;
    bit               m_cap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            m_cap = en && slow_valid && ((m_cyc % DIV) == DIV / 2 - 1);
            if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (m_cap) begin
                if (m_q.size() < 2) begin
                    m_q.push_back(slow_data);
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (en) m_cyc++;
        end
    end

    function automatic int m_ph();
        return m_cyc % DIV;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go_to_phase(input int p);
        for (int i = 0; i < DIV + 1 && m_ph() != p; i++) tick();
        n_cmp++;
        if (phase !== 2'(p)) begin
            n_err++;
            $display("FAIL goto_phase got %0d want %0d", phase, p);
        end
    endtask

    task automatic do_capture(input logic [WIDTH-1:0] w);
        go_to_phase(DIV / 2 - 1);
        slow_valid = 1'b1;
        slow_data  = w;
        tick();
        slow_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_ph[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_dc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (phase !== 2'd0 || div_clk !== 1'b0) begin
            n_err++;
            $display("FAIL reset_div got ph=%0d dc=%b want 0 0", phase, div_clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_fifo got v=%b o=%b d=%h want 0 0 00", out_valid, overflow, out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (phase !== exp_ph[i] || div_clk !== exp_dc[i]) begin
                n_err++;
                $display("FAIL idle_seq[%0d] got ph=%0d dc=%b want %0d %b", i, phase, div_clk, exp_ph[i], exp_dc[i]);
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL idle_flags got v=%b o=%b want 0 0", out_valid, overflow);
        end
    endtask

    task automatic test_single_capture();
        out_ready  = 1'b1;
        slow_valid = 1'b1;
        slow_data  = 8'hA5;
        tick();
        tick();
        slow_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_cap got v=%b d=%h want 1 a5", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_enable_gating();
        out_ready = 1'b1;
        go_to_phase(1);
        en = 1'b0;
        slow_valid = 1'b1;
        slow_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (phase !== 2'd1 || div_clk !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL en_hold[%0d] got ph=%0d dc=%b v=%b want 1 0 0", i, phase, div_clk, out_valid);
            end
        end
        en = 1'b1;
        tick();
        slow_valid = 1'b0;
        n_cmp++;
        if (phase !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_err++;
            $display("FAIL en_resume got ph=%0d v=%b d=%h want 2 1 5a", phase, out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        do_capture(8'h11);
        do_capture(8'h22);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL bp_noovf got %b want 0", overflow);
        end
        do_capture(8'h33);
        n_cmp++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_err++;
            $display("FAIL bp_full got o=%b v=%b d=%h want 1 1 11", overflow, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_err++;
            $display("FAIL bp_second got v=%b d=%h want 1 22", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drained got v=%b o=%b want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        out_ready = 1'b0;
        do_capture(8'h11);
        do_capture(8'h22);
        go_to_phase(1);
        slow_valid = 1'b1;
        slow_data  = 8'h44;
        out_ready  = 1'b1;
        n_cmp++;
        if (out_data !== 8'h11) begin
            n_err++;
            $display("FAIL pp_head got %h want 11", out_data);
        end
        tick();
        slow_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_err++;
            $display("FAIL pp_second got v=%b d=%h want 1 22", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h44) begin
            n_err++;
            $display("FAIL pp_third got v=%b d=%h want 1 44", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL pp_end got v=%b o=%b want 0 0", out_valid, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        do_capture(8'h11);
        do_capture(8'h22);
        do_capture(8'h33);
        n_cmp++;
        if (out_valid !== 1'b1 || div_clk !== 1'b1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre got v=%b dc=%b o=%b want 1 1 1", out_valid, div_clk, overflow);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || div_clk !== 1'b0 || overflow !== 1'b0 || phase !== 2'd0) begin
            n_err++;
            $display("FAIL ar_now got v=%b dc=%b o=%b ph=%0d want 0 0 0 0", out_valid, div_clk, overflow, phase);
        end
`ifdef GENCLK_RETURN_COUNT_EN
        n_cmp++;
        if (cap_count !== 16'd0) begin
            n_err++;
            $display("FAIL ar_count got %0d want 0", cap_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            en         = ($urandom_range(0, 9) != 0);
            slow_valid = ($urandom_range(0, 1) != 0);
            slow_data  = 8'($urandom);
            out_ready  = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            tick();
            n_cmp++;
            if (phase !== 2'(m_ph()) || div_clk !== (m_ph() >= DIV / 2)) begin
                n_err++;
                $display("FAIL rnd_div[%0d] got ph=%0d dc=%b want %0d", i, phase, div_clk, m_ph());
            end
            n_cmp++;
            if (out_valid !== (m_q.size() != 0) || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rnd_flags[%0d] got v=%b o=%b want %b %b", i, out_valid, overflow, m_q.size() != 0, m_ovf);
            end
            if (m_q.size() != 0) begin
                n_cmp++;
                if (out_data !== m_q[0]) begin
                    n_err++;
                    $display("FAIL rnd_data[%0d] got %h want %h", i, out_data, m_q[0]);
                end
            end
`ifdef GENCLK_RETURN_COUNT_EN
            n_cmp++;
            if (cap_count !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL rnd_count[%0d] got %0d want %0d", i, cap_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_enable_gating();
        test_back_pressure();
        test_full_pushpop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/genclk_return_capture.md
Name: genclk_return_capture

Overview:
- Single-clock block that regenerates a divide-by-DIV clock from `clk` and drives it out as a registered `div_clk`.
- It carries data the opposite way to the usual fast-to-slow launch. Words launched by registers clocked on `div_clk` are captured back into the `clk` domain at a fixed safe phase.
- Captured words are buffered in a 2-entry FIFO and presented on a valid/ready handshake.
- Serves as the return path of the divided-clock test structures, so STA exercises slow-to-fast paths and multicycle capture.

Parameters:
- DIV, 4, division ratio. Even, >= 2.
- WIDTH, 8, data word width.

Ports:
- clk  input  1  base clock; all state is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  divider run enable
- div_clk  output  1  registered divided clock (DIV/2 cycles low, then DIV/2 cycles high)
- slow_data  input  WIDTH  word launched on `div_clk` rising edges
- slow_valid  input  1  qualifier launched alongside `slow_data`
- out_data  output  WIDTH  FIFO head word
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts head
- overflow  output  1  sticky: a capture was lost
- phase  output  $clog2(DIV)  current divider phase, for debug

Behaviour:
- Reset (asynchronous, rst_n=0):
  - phase=0, div_clk=0
  - FIFO empty, out_valid=0, out_data=0
  - overflow=0
  - All take effect immediately, with no clock required.
- Divider:
  - With en=1, phase increments by 1 each clk and wraps from DIV-1 to 0.
  - With en=0, phase and div_clk hold.
  - div_clk is registered as (next_phase >= DIV/2), so it rises on the edge where phase becomes DIV/2 and falls on the edge where phase becomes 0.
  - div_clk has no combinational path from inputs.
- Capture strobe:
  - cap = en && (phase == DIV/2-1) && slow_valid. This is the last fast cycle before the next `div_clk` rise, so slow data has had a full slow period minus one fast cycle to settle.
  - When cap=1, slow_data is written into the FIFO on that edge.
- FIFO:
  - 2 entries: head and tail registers plus a 2-bit count.
  - out_valid=(count!=0); out_data = head entry, registered and not combinational from slow_data.
  - Latency: capture edge -> out_valid high in the next cycle, i.e. 1 clk.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: count is unchanged, order is preserved. With count=1, the pushed word becomes head after the pop.
  - Push when count==2 and no pop: the word is dropped, FIFO is unchanged, overflow is set.
  - Push when count==2 with a simultaneous pop: the push is accepted.
  - overflow clears only on reset.
- en deassertion mid-period: phase freezes and no captures occur. On re-enable, phase resumes from the frozen value.
- Reset mid-operation discards FIFO contents. div_clk goes low asynchronously.
- DIV=2 corner case: strobe phase is 0, so a capture may occur every other clk.

Optional Feature:
- Macro: GENCLK_RETURN_COUNT_EN.
- When defined:
  - Adds output `cap_count` [15:0], reset to 0.
  - Increments on every accepted push and saturates at 16'hFFFF.
  - Dropped pushes do not count.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 for 3 clk, then release with en=1, DIV=4 -> phase sequence 0,1,2,3,0, and div_clk = 0,0,1,1,0 after each edge. out_valid=0, overflow=0.
- Single capture: slow_valid=1, slow_data=8'hA5 held across phase 1 with out_ready=1 -> cap on the phase-1 edge. Next cycle out_valid=1 and out_data=8'hA5; the following cycle out_valid=0.
- Back-pressure: out_ready=0, three captures 8'h11, 8'h22, 8'h33 in successive slow periods -> FIFO holds 11,22 and overflow=1 after the third capture. Then out_ready=1 yields 11 then 22, and 33 is never seen.
- Simultaneous push/pop at full: count=2 with out_ready=1 on the capture edge of 8'h44 -> pops 11, then 22, then 44, with overflow staying 0.
- Enable gating: drop en at phase 1 for 5 clk -> phase stays 1, div_clk stays 0, and no capture occurs despite slow_valid=1. On re-enable, the capture fires on the first enabled edge at phase 1.
- Async reset mid-stream: with count=2, assert rst_n between edges -> out_valid, div_clk and overflow are 0 immediately. With GENCLK_RETURN_COUNT_EN defined, cap_count=0.
